// File: rtl/sram_like_slave_if.sv
// Bus bundle for sram_like_slave: sram_like request/response side plus the SRAM side.
interface sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  req, wr, size, addr, wdata, sram_rdata,
    output addr_ok, data_ok, rdata, sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output req, wr, size, addr, wdata, sram_rdata,
    input  addr_ok, data_ok, rdata, sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_like_slave.sv
// Single-outstanding sram_like slave bridging to a synchronous SRAM.
// Optional response wait states enabled by defining SRAM_LIKE_WAIT_EN.
module sram_like_slave #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic              clk,
  input logic              resetn,
  sram_like_slave_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  if (WAIT_CYCLES > 15) begin : g_wait_range
    $error("WAIT_CYCLES must be in 0..15");
  end

`ifdef SRAM_LIKE_WAIT_EN
  localparam logic [3:0] WAIT_EFF = 4'(WAIT_CYCLES);
`else
  localparam logic [3:0] WAIT_EFF = '0;
`endif

  state_t      state, state_next;
  logic        accept;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic        capture_q;
  logic [3:0]  wen_calc;

  assign accept      = resetn && (state == IDLE) && bus.req;
  assign bus.addr_ok = accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

`ifdef SRAM_LIKE_WAIT_EN
  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                cnt_q <= '0;
    else if (state == ACCESS)   cnt_q <= WAIT_EFF;
    else if (state == WAIT)     cnt_q <= cnt_q - 4'd1;
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = (WAIT_EFF == '0) ? RESP : WAIT;
`ifdef SRAM_LIKE_WAIT_EN
      WAIT:    if (cnt_q == 4'd1) state_next = RESP;
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      capture_q <= 1'b0;
    end else begin
      capture_q <= (state == ACCESS);
      if (capture_q) rbuf_q <= bus.sram_rdata;
      if (accept) begin
        wr_q    <= bus.wr;
        size_q  <= bus.size;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   wen_calc = 4'b0001 << addr_q[1:0];
      2'b01:   wen_calc = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wen_calc = 4'b1111;
    endcase
  end

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wen   = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    bus.data_ok    = 1'b0;
    bus.rdata      = '0;
    case (state)
      ACCESS: begin
        bus.sram_en    = 1'b1;
        bus.sram_addr  = {addr_q[31:2], 2'b00};
        bus.sram_wdata = wdata_q;
        if (wr_q) bus.sram_wen = wen_calc;
      end
      RESP: begin
        bus.data_ok = 1'b1;
        // With no wait states RESP is the capture cycle itself, so the SRAM word passes straight through.
        if (!wr_q) bus.rdata = capture_q ? bus.sram_rdata : rbuf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed, table-driven bench for sram_like_slave plus back-to-back and reset-abort sequences.
module tb_sram_like_slave;

`ifdef SRAM_LIKE_WAIT_EN
  localparam int unsigned W = 3;
`else
  localparam int unsigned W = 0;
`endif

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  sram_like_slave_if bus ();

  sram_like_slave #(.WAIT_CYCLES(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] srdata;
    logic [3:0]  exp_wen;
    logic [31:0] exp_saddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".addr_ok"},    32'(bus.addr_ok),  32'h0);
    chk({tag, ".data_ok"},    32'(bus.data_ok),  32'h0);
    chk({tag, ".rdata"},      bus.rdata,         32'h0);
    chk({tag, ".sram_en"},    32'(bus.sram_en),  32'h0);
    chk({tag, ".sram_wen"},   32'(bus.sram_wen), 32'h0);
    chk({tag, ".sram_addr"},  bus.sram_addr,     32'h0);
    chk({tag, ".sram_wdata"}, bus.sram_wdata,    32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    bus.req = 1'b1; bus.wr = v.wr; bus.size = v.size;
    bus.addr = v.addr; bus.wdata = v.wdata; bus.sram_rdata = 32'h5A5A_0000;
    #1 chk({tag, ".addr_ok"}, 32'(bus.addr_ok), 32'h1);
    chk({tag, ".sram_en_idle"}, 32'(bus.sram_en), 32'h0);
    @(negedge clk);
    // scramble inputs after acceptance; the in-flight transfer must not notice
    bus.req = 1'b0; bus.wr = ~v.wr; bus.size = ~v.size;
    bus.addr = ~v.addr; bus.wdata = ~v.wdata;
    #1;
    chk({tag, ".sram_en"},    32'(bus.sram_en),  32'h1);
    chk({tag, ".sram_wen"},   32'(bus.sram_wen), 32'(v.exp_wen));
    chk({tag, ".sram_addr"},  bus.sram_addr,     v.exp_saddr);
    chk({tag, ".sram_wdata"}, bus.sram_wdata,    v.wdata);
    chk({tag, ".access_dok"}, 32'(bus.data_ok),  32'h0);
    for (int unsigned c = 2; c <= 2 + W; c++) begin
      @(negedge clk);
      bus.sram_rdata = (c == 2) ? v.srdata : (32'hBAD0_0000 | c);
      #1;
      chk({tag, ".sram_en_off"}, 32'(bus.sram_en), 32'h0);
      if (c < 2 + W) begin
        chk({tag, ".wait_dok"}, 32'(bus.data_ok), 32'h0);
      end else begin
        chk({tag, ".data_ok"}, 32'(bus.data_ok), 32'h1);
        chk({tag, ".rdata"},   bus.rdata,        v.exp_rdata);
      end
    end
    @(negedge clk);
    bus.sram_rdata = 32'hC0DE_C0DE;
    #1;
    chk({tag, ".dok_after"},   32'(bus.data_ok), 32'h0);
    chk({tag, ".rdata_after"}, bus.rdata,        32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //         wr    size   addr          wdata         srdata        wen      saddr         rdata
    vecs[0] = '{1'b0, 2'b10, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 4'b0000, 32'h0000_1004, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 2'b00, 32'h0000_2003, 32'hAB00_0000, 32'h1111_1111, 4'b1000, 32'h0000_2000, 32'h0};
    vecs[2] = '{1'b1, 2'b01, 32'h0000_0010, 32'h0000_BEEF, 32'h2222_2222, 4'b0011, 32'h0000_0010, 32'h0};
    vecs[3] = '{1'b1, 2'b01, 32'h0000_0012, 32'hCAFE_0000, 32'h3333_3333, 4'b1100, 32'h0000_0010, 32'h0};
    vecs[4] = '{1'b1, 2'b11, 32'h0000_0024, 32'h0123_4567, 32'h4444_4444, 4'b1111, 32'h0000_0024, 32'h0};
    vecs[5] = '{1'b1, 2'b00, 32'h0000_0031, 32'h0000_5500, 32'h5555_5555, 4'b0010, 32'h0000_0030, 32'h0};
    vecs[6] = '{1'b1, 2'b01, 32'h0000_0013, 32'h7777_0000, 32'h6666_6666, 4'b1100, 32'h0000_0010, 32'h0};
    vecs[7] = '{1'b0, 2'b00, 32'hFFFF_FFFE, 32'h0,        32'h1234_5678, 4'b0000, 32'hFFFF_FFFC, 32'h1234_5678};
    vecs[8] = '{1'b1, 2'b10, 32'h8000_0040, 32'h89AB_CDEF, 32'h7777_7777, 4'b1111, 32'h8000_0040, 32'h0};

    resetn = 1'b0;
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b10;
    bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'hFFFF_FFFF; bus.sram_rdata = 32'hFFFF_FFFF;
    #2 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    chk_all_zero("reset_clk");
    bus.req = 1'b0;
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // back-to-back reads with req held high
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'b10;
    bus.addr = 32'h0000_0080; bus.sram_rdata = 32'h1111_2222;
    for (int unsigned c = 0; c <= 5 + 2 * W; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 4 + W) bus.req = 1'b0;
      #1;
      chk($sformatf("b2b.addr_ok.c%0d", c), 32'(bus.addr_ok),
          32'((c == 0) || (c == 3 + W)));
      chk($sformatf("b2b.data_ok.c%0d", c), 32'(bus.data_ok),
          32'((c == 2 + W) || (c == 5 + 2 * W)));
      if ((c == 2 + W) || (c == 5 + 2 * W))
        chk($sformatf("b2b.rdata.c%0d", c), bus.rdata, 32'h1111_2222);
    end

    // reset asserted between clock edges mid-transaction
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b10;
    bus.addr = 32'h0000_0100; bus.wdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_all_zero("abort");
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("abort.hold_dok", 32'(bus.data_ok), 32'h0);
      chk("abort.hold_en",  32'(bus.sram_en), 32'h0);
    end
    @(negedge clk);
    bus.req = 1'b0;
    resetn = 1'b1;
    #1;
    chk("abort.release_en",  32'(bus.sram_en), 32'h0);
    chk("abort.release_dok", 32'(bus.data_ok), 32'h0);
    @(negedge clk);
    #1 chk("abort.idle_dok", 32'(bus.data_ok), 32'h0);
    run_vec(vecs[0], "post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected done");
    $fatal(1, "timeout");
  end

endmodule
